// File: rtl/xadc_drp_pkg.sv
// Shared types and constants for the XADC DRP responder model.
// Holds the DRP handshake state encoding, the register-map bases and the
// packing function that produces deterministic conversion sample values.
package xadc_drp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } drp_state_t;

    localparam logic [6:0] STATUS_BASE = 7'h00;
    localparam logic [6:0] CONFIG_BASE = 7'h40;
    localparam int         REG_COUNT   = 128;

    // Sample word: channel number in the top five bits, sequence number below.
    function automatic logic [15:0] sample_value(input logic [4:0]  ch,
                                                 input logic [10:0] seq);
        return {ch, seq};
    endfunction

endpackage

// File: rtl/xadc_seq_gen.sv
// Conversion sequencer for the XADC DRP responder model.
// A free-running conversion counter drives busy; at the end of each
// conversion a status word is handed to the parent register file and
// eoc (plus eos on the last channel) pulses for one cycle. A restart
// request re-aligns the counter and channel without touching seq_num.
module xadc_seq_gen
    import xadc_drp_pkg::*;
#(
    parameter int SEQ_PERIOD   = 32,
    parameter int SEQ_CHANNELS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    output logic        busy,
    output logic        eoc,
    output logic        eos,
    output logic [4:0]  channel,
    output logic        stat_we,
    output logic [6:0]  stat_addr,
    output logic [15:0] stat_data
);

    localparam int             CW       = (SEQ_PERIOD > 1) ? $clog2(SEQ_PERIOD) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SEQ_PERIOD - 1);
    localparam logic [CW-1:0]  CNT_PRE  = CW'(SEQ_PERIOD - 2);
    localparam logic [4:0]     CH_LAST  = 5'(SEQ_CHANNELS - 1);

    logic [CW-1:0] cnt_reg;
    logic [4:0]    ch_reg;
    logic [10:0]   seq_reg;
    logic          eoc_reg;
    logic          eos_reg;
    logic [4:0]    channel_reg;

    logic conv_done;
    logic wrap;

    // conv_done marks the edge into the final count, where results are
    // published so that eoc, channel and the status word appear together
    // with busy dropping.
    assign conv_done = (cnt_reg == CNT_PRE);
    assign wrap      = (cnt_reg == CNT_LAST);

    // Conversion counter, channel/sequence tracking and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            ch_reg      <= '0;
            seq_reg     <= '0;
            eoc_reg     <= 1'b0;
            eos_reg     <= 1'b0;
            channel_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
            ch_reg  <= '0;
            eoc_reg <= 1'b0;
            eos_reg <= 1'b0;
        end else begin
            eoc_reg <= conv_done;
            eos_reg <= conv_done && (ch_reg == CH_LAST);
            if (conv_done) begin
                channel_reg <= ch_reg;
            end
            if (wrap) begin
                cnt_reg <= '0;
                if (ch_reg == CH_LAST) begin
                    ch_reg  <= '0;
                    seq_reg <= seq_reg + 11'd1;
                end else begin
                    ch_reg <= ch_reg + 5'd1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign busy      = (cnt_reg != CNT_LAST);
    assign eoc       = eoc_reg;
    assign eos       = eos_reg;
    assign channel   = channel_reg;
    assign stat_we   = conv_done && !restart;
    assign stat_addr = STATUS_BASE + {2'b00, ch_reg};
    assign stat_data = sample_value(ch_reg, seq_reg);

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP responder model: 128x16 register file, DRP handshake FSM and
// conversion sequencer. Status space (0x00-0x3F) is filled by the
// sequencer and ignores DRP writes; config space (0x40-0x7F) is DRP
// read/write and any write there restarts the sequencer.
// Optional protocol checker: define XADC_DRP_PROTO_CHECK_EN to build the
// sticky err flag; otherwise err is tied low.
module xadc_drp_responder
    import xadc_drp_pkg::*;
#(
    parameter int RD_LATENCY   = 4,
    parameter int SEQ_PERIOD   = 32,
    parameter int SEQ_CHANNELS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        den,
    input  logic        dwe,
    input  logic [6:0]  daddr,
    input  logic [15:0] di,
    output logic [15:0] dout,
    output logic        drdy,
    output logic        busy,
    output logic        eoc,
    output logic        eos,
    output logic [4:0]  channel,
    output logic        err
);

    localparam int         WAIT_LAST_I = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [3:0] WAIT_LAST   = 4'(WAIT_LAST_I);

    drp_state_t  state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0] rdata_reg, rdata_next;

    logic [15:0] regs [REG_COUNT];

    logic        den_idle;
    logic        cfg_wr;
    logic        stat_we;
    logic [6:0]  stat_addr;
    logic [15:0] stat_data;

    // Only a den accepted in IDLE starts a transaction; config writes commit
    // on that same edge and restart the sequencer.
    assign den_idle = den && (state_reg == IDLE);
    assign cfg_wr   = den_idle && dwe && (daddr >= CONFIG_BASE);

    // Register file: sequencer owns status words, DRP owns config words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (stat_we) begin
                regs[stat_addr] <= stat_data;
            end
            if (cfg_wr) begin
                regs[daddr] <= di;
            end
        end
    end

    // DRP handshake state, latency counter and captured read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Next-state logic; reads sample the array before same-edge updates land.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (den) begin
                    rdata_next    = dwe ? 16'h0000 : regs[daddr];
                    wait_cnt_next = '0;
                    state_next    = (RD_LATENCY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ACK;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign drdy = (state_reg == ACK);
    assign dout = drdy ? rdata_reg : 16'h0000;

`ifdef XADC_DRP_PROTO_CHECK_EN
    logic err_reg;

    // Sticky flag for den while a transaction is in flight or a status write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (den && ((state_reg != IDLE) || (dwe && (daddr < CONFIG_BASE)))) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    xadc_seq_gen #(
        .SEQ_PERIOD   (SEQ_PERIOD),
        .SEQ_CHANNELS (SEQ_CHANNELS)
    ) u_seq_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (cfg_wr),
        .busy      (busy),
        .eoc       (eoc),
        .eos       (eos),
        .channel   (channel),
        .stat_we   (stat_we),
        .stat_addr (stat_addr),
        .stat_data (stat_data)
    );

endmodule
